// File: rtl/op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : op_sequencer
// Brief    : Opcode-driven sequencer (IDLE->ASK->CHOOSE->exec->DONE) computing
//            multiply / add / subtract, plus divide when OP_SEQ_DIVIDE_EN is
//            defined.
// Revision : 1.0
// ============================================================================
module op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag,
    output logic                 err,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ASK    = 3'd1,
        S_CHOOSE = 3'd2,
        S_MUL    = 3'd3,
        S_ADD    = 3'd4,
        S_SUB    = 3'd5,
        S_DIV    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [1:0]           r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_flag;
    logic                 r_err;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_last;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
    assign w_acc_nxt = r_b[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last    = (r_cnt == c_last);

`ifdef OP_SEQ_DIVIDE_EN
    // Restoring divide: r_a shifts the dividend out of its MSB while the
    // quotient bits shift in at its LSB.
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_try;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;

    assign w_rem_sh  = {r_rem, r_a[WIDTH-1]};
    assign w_try     = w_rem_sh - {1'b0, r_b};
    assign w_ge      = ~w_try[WIDTH];
    assign w_rem_nxt = w_ge ? w_try[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_a[WIDTH-2:0], w_ge};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flag   <= 1'b0;
            r_err    <= 1'b0;
`ifdef OP_SEQ_DIVIDE_EN
            r_rem    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= opcode;
                        r_busy  <= 1'b1;
                        r_state <= S_ASK;
                    end
                end
                S_ASK: begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_mcand <= {{WIDTH{1'b0}}, r_a};
`ifdef OP_SEQ_DIVIDE_EN
                    r_rem   <= '0;
`endif
                    r_state <= S_CHOOSE;
                end
                S_CHOOSE: begin
                    case (r_op)
                        2'd0: r_state <= S_MUL;
                        2'd1: r_state <= S_ADD;
                        2'd2: r_state <= S_SUB;
                        default: begin
`ifdef OP_SEQ_DIVIDE_EN
                            r_state <= S_DIV;
`else
                            r_result <= '0;
                            r_flag   <= 1'b0;
                            r_err    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
`endif
                        end
                    endcase
                end
                S_MUL: begin
                    // Fixed WIDTH iterations regardless of operand values.
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_flag   <= 1'b0;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_ADD: begin
                    r_result <= {{(WIDTH-1){1'b0}}, w_sum};
                    r_flag   <= w_sum[WIDTH];
                    r_err    <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_SUB: begin
                    r_result <= {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                    r_flag   <= w_diff[WIDTH];
                    r_err    <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
`ifdef OP_SEQ_DIVIDE_EN
                S_DIV: begin
                    if (r_b == '0) begin
                        r_result <= {r_a, {WIDTH{1'b1}}};
                        r_flag   <= 1'b0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_a   <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= {w_rem_nxt, w_quo_nxt};
                            r_flag   <= 1'b0;
                            r_err    <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flag   = r_flag;
    assign err    = r_err;
    assign state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_sequencer
// Brief    : Scoreboard bench for op_sequencer (WIDTH=8); honours OP_SEQ_DIVIDE_EN.
// Revision : 1.0
// ============================================================================
module tb_op_sequencer;
    localparam int W  = 8;
    localparam int RW = 2 * W;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          start  = 1'b0;
    logic [1:0]    opcode = '0;
    logic [W-1:0]  a      = '0;
    logic [W-1:0]  b      = '0;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          flag;
    logic          err;
    logic [2:0]    state;

    op_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag),
        .err    (err),
        .state  (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] res;
        logic          flag;
        logic          err;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   hold_mode   = 1'b0;
    int   prev_due    = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic; due is the cycle count at
    // which done should be observed, given capture on edge k.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int k);
        exp_t   e;
        longint xa;
        longint yb;
        xa     = longint'(x);
        yb     = longint'(y);
        e.res  = '0;
        e.flag = 1'b0;
        e.err  = 1'b0;
        e.due  = k + 3;
        case (op)
            2'd0: begin
                e.res = RW'(xa * yb);
                e.due = k + 2 + W;
            end
            2'd1: begin
                e.res  = RW'(xa + yb);
                e.flag = (xa + yb) > longint'(2**W - 1);
            end
            2'd2: begin
                e.res  = RW'((xa - yb + longint'(2**W)) % longint'(2**W));
                e.flag = (xa < yb);
            end
            default: begin
`ifdef OP_SEQ_DIVIDE_EN
                if (yb == 0) begin
                    e.res = RW'(xa * longint'(2**W) + longint'(2**W - 1));
                    e.err = 1'b1;
                end else begin
                    e.res = RW'((xa % yb) * longint'(2**W) + xa / yb);
                    e.due = k + 2 + W;
                end
`else
                e.err = 1'b1;
                e.due = k + 2;
`endif
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1 with no request outstanding, expected 0");
            end else begin
                e = sb.pop_front();
                chk("result",  64'(result), 64'(e.res));
                chk("flag",    64'(flag),   64'(e.flag));
                chk("err",     64'(err),    64'(e.err));
                chk("latency", 64'(cyc),    64'(e.due));
            end
        end
    end

    // Called at a negedge; waits for IDLE, then presents one request.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int   n;
        exp_t e;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            opcode = 2'($urandom);
            a      = W'($urandom);
            b      = W'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy=%0b after %0d cycles, expected 0", busy, n);
            return;
        end
        e = model(op, xa, xb, cyc + 1);
        if (hold_mode && prev_due >= 0)
            chk("idle_gap", 64'(cyc), 64'(prev_due + 1));
        prev_due = e.due;
        sb.push_back(e);
        start  = 1'b1;
        opcode = op;
        a      = xa;
        b      = xb;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'd1);
        if (!hold_mode) start = 1'b0;
        opcode = 2'($urandom);
        a      = W'($urandom);
        b      = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"},  64'(state),  64'd0);
        chk({tag, "_busy"},   64'(busy),   64'd0);
        chk({tag, "_done"},   64'(done),   64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_flag"},   64'(flag),   64'd0);
        chk({tag, "_err"},    64'(err),    64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_reset_outputs("por");
        end
        reset = 1'b1;
        @(negedge clk);
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_busy",  64'(busy),  64'd0);

        issue(2'd0, 8'd13, 8'd11);
        drain();
        issue(2'd1, 8'd200, 8'd100);
        issue(2'd1, 8'd3,   8'd4);
        issue(2'd2, 8'd5,   8'd7);
        issue(2'd2, 8'd7,   8'd5);
        issue(2'd3, 8'd100, 8'd7);
        issue(2'd3, 8'd100, 8'd0);
        issue(2'd0, 8'd0,   8'd200);
        issue(2'd0, 8'd200, 8'd0);
        issue(2'd1, 8'd255, 8'd255);
        issue(2'd2, 8'd0,   8'd255);
        issue(2'd3, 8'd255, 8'd1);
        drain();

        // Abort a multiply with reset partway through.
        issue(2'd0, 8'd255, 8'd255);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        chk_reset_outputs("abort_hold");
        reset = 1'b1;
        @(negedge clk);
        issue(2'd0, 8'd255, 8'd255);
        drain();

        // start held high: each operation must re-trigger one cycle after DONE.
        hold_mode = 1'b1;
        prev_due  = -1;
        for (int i = 0; i < 6; i++)
            issue(2'($urandom_range(0, 3)), pick(), pick());
        hold_mode = 1'b0;
        start     = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
Parametrised successor to the team's opcode-driven task state machine. Runs the fixed IDLE -> ASK_TASK -> CHOOSE_TASK -> execute -> DONE sequence, and also computes results:
- WIDTH-bit unsigned operands
- start/busy/done handshake
- multi-cycle shift-add multiply
- carry/borrow and error flags

Sits between a command source (sequencer or bus wrapper) and the datapath consumer of the results.

Parameters:
WIDTH, 8, operand width in bits (2..32)
CNT_W, $clog2(WIDTH)+1, internal iteration-counter width (derived; do not override)

Ports:
clk      input   1        rising-edge clock
reset    input   1        asynchronous, active-low reset (0 = reset asserted)
start    input   1        request; sampled only in IDLE
opcode   input   2        0=MULTIPLY, 1=ADD, 2=SUBTRACT, 3=DIVIDE (DIVIDE only with optional feature)
a        input   WIDTH    operand A, captured with start
b        input   WIDTH    operand B, captured with start
busy     output  1        high in every state except IDLE
done     output  1        one-cycle pulse in DONE state
result   output  2*WIDTH  result; held until next accepted start
flag     output  1        ADD carry / SUB borrow; else 0
err      output  1        illegal opcode or divide-by-zero; valid with done
state    output  3        current state (debug)

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, result=0, flag=0, err=0; operand registers and counter cleared. Reset mid-operation aborts immediately; no done pulse is issued.
- State encoding: IDLE=0, ASK_TASK=1, CHOOSE_TASK=2, MULTIPLY=3, ADD=4, SUBTRACT=5, DIVIDE=6, DONE=7.
- IDLE: if start=1 at edge k, capture a, b, opcode; go to ASK_TASK. result/flag/err keep their previous values until DONE.
- ASK_TASK: one cycle. Clear accumulator and counter; go to CHOOSE_TASK.
- CHOOSE_TASK: one cycle. Branch on captured opcode. Opcode 3 with the feature absent: go to DONE with err=1, result=0.
- ADD: one cycle. result = {zeros, a+b} (WIDTH+1 bits zero-extended); flag = carry out.
- SUBTRACT: one cycle. result low WIDTH bits = (a-b) mod 2^WIDTH, upper bits 0; flag = (a<b).
- MULTIPLY: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles. result = a*b (full 2*WIDTH); flag=0.
- DONE: done=1 for exactly one cycle; outputs updated on entry; return to IDLE.
- Latency (start edge k to done high):
  - ADD/SUB/illegal: done high in cycle k+4 (illegal skips exec: k+3)
  - MULTIPLY: k+3+WIDTH
- start while busy is ignored and not queued. start held high continuously re-triggers on the cycle after DONE (IDLE visited for one cycle).
- Operand/opcode inputs may change after capture without effect.
- Edge cases: a=0 or b=0 for MULTIPLY still takes WIDTH cycles (fixed latency); all-ones operands must not overflow 2*WIDTH.

Optional Feature:
Macro OP_SEQ_DIVIDE_EN.
- Defined: opcode 3 = unsigned restoring divide, WIDTH cycles in DIVIDE state.
  - result = {remainder, quotient} (quotient in low WIDTH bits); flag=0.
  - b=0: skip iterations, quotient = all ones, remainder = a, err=1.
  - Latency k+3+WIDTH (divide-by-zero: k+4).
- Not defined: DIVIDE state and divider logic absent; opcode 3 is illegal (err=1, result=0, done at k+3).

Test Plan:
1. WIDTH=8, reset low 2 cycles then high: every output 0 and state=0 through reset; start=1, opcode=0, a=13, b=11 -> busy next cycle; done at k+11; result=16'h008F, flag=0, err=0.
2. opcode=1, a=200, b=100 -> done at k+4; result=16'h012C, flag=1. Then a=3, b=4 -> result=16'h0007, flag=0.
3. opcode=2, a=5, b=7 -> done at k+4; result=16'h00FE, flag=1. Then a=7, b=5 -> result=16'h0002, flag=0.
4. opcode=3:
   - Macro undefined -> done at k+3, err=1, result=0.
   - Macro defined, a=100, b=7 -> done at k+11, result=16'h020E.
   - Macro defined, b=0 -> err=1, result=16'h64FF.
5. Start MULTIPLY 255*255; pull reset low at k+6 -> immediate IDLE with all outputs 0 and no done pulse. Restart -> result=16'hFE01 at k+11.
6. start held high during MULTIPLY, with opcode toggling -> no re-capture while busy. Exactly one done per operation; next operation starts one cycle after DONE.
